// File: rtl/cache_refill_ctrl_if.sv
// Bundle of the handshake and array-side buses around cache_refill_ctrl.
// The master modport is the refill controller; the slave modport is the
// surrounding cache_ctrl / memory / data-array / tag-array environment.
interface cache_refill_ctrl_if #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int IDXW = 4,
  parameter int TAGW = AW - IDXW - 2
);
  logic            miss_valid;
  logic            miss_ready;
  logic [AW-1:0]   miss_addr;
  logic [1:0]      miss_way;
  logic            victim_dirty;
  logic [TAGW-1:0] victim_tag;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_we;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic            arr_we;
  logic            arr_re;
  logic [1:0]      arr_way;
  logic [IDXW-1:0] arr_index;
  logic [1:0]      arr_word;
  logic [DW-1:0]   arr_wdata;
  logic [DW-1:0]   arr_rdata;
  logic            tag_we;
  logic [TAGW:0]   tag_wdata;
  logic            fill_done;

  modport master (
    input  miss_valid, miss_addr, miss_way, victim_dirty, victim_tag,
           mem_req_ready, mem_rvalid, mem_rdata, arr_rdata,
    output miss_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_wdata,
           arr_we, arr_re, arr_way, arr_index, arr_word, arr_wdata,
           tag_we, tag_wdata, fill_done
  );

  modport slave (
    output miss_valid, miss_addr, miss_way, victim_dirty, victim_tag,
           mem_req_ready, mem_rvalid, mem_rdata, arr_rdata,
    input  miss_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_wdata,
           arr_we, arr_re, arr_way, arr_index, arr_word, arr_wdata,
           tag_we, tag_wdata, fill_done
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Line-refill sequencer: on a miss, burst-reads a 4-word line from memory,
// writes each beat into the chosen way of the data array in order 0..3,
// then installs {valid, tag} and pulses fill_done.
// Optional dirty-victim writeback is compiled in with REFILL_WRITEBACK_EN;
// without it victim_dirty is ignored and mem_req_we stays 0.
module cache_refill_ctrl #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int IDXW = 4,
  parameter int TAGW = AW - IDXW - 2
) (
  input logic                  clk,
  input logic                  rstn,
  cache_refill_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    TAG
`ifdef REFILL_WRITEBACK_EN
    ,
    WB_RD,
    WB_WR
`endif
  } state_t;

  state_t          state;
  logic [1:0]      cnt;
  logic            miss_ready_q;
  logic            tag_we_q;
  logic            fill_done_q;
  logic [TAGW:0]   tag_wdata_q;
  logic [TAGW-1:0] tag_q;
  logic [IDXW-1:0] idx_q;
  logic [1:0]      way_q;

`ifdef REFILL_WRITEBACK_EN
  logic [TAGW-1:0] vtag_q;
  logic [DW-1:0]   wb_hold_q;
  logic            wb_first_q;
  logic            unused_bits;
  assign unused_bits = ^bus.miss_addr[1:0];
`else
  logic            unused_bits;
  assign unused_bits = ^{bus.miss_addr[1:0], bus.victim_dirty, bus.victim_tag, bus.arr_rdata};
`endif

  // Control FSM: state, shared beat/word counter and the registered strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      miss_ready_q <= 1'b1;
      tag_we_q     <= 1'b0;
      fill_done_q  <= 1'b0;
      tag_wdata_q  <= '0;
`ifdef REFILL_WRITEBACK_EN
      wb_first_q   <= 1'b0;
`endif
    end else begin
      tag_we_q    <= 1'b0;
      fill_done_q <= 1'b0;
      tag_wdata_q <= '0;
`ifdef REFILL_WRITEBACK_EN
      wb_first_q  <= (state == WB_RD);
`endif
      case (state)
        IDLE: begin
          if (bus.miss_valid) begin
            miss_ready_q <= 1'b0;
            cnt          <= 2'd0;
`ifdef REFILL_WRITEBACK_EN
            state        <= bus.victim_dirty ? WB_RD : REQ;
`else
            state        <= REQ;
`endif
          end
        end
`ifdef REFILL_WRITEBACK_EN
        WB_RD: state <= WB_WR;
        WB_WR: begin
          if (bus.mem_req_ready) begin
            cnt   <= cnt + 2'd1;
            state <= (cnt == 2'd3) ? REQ : WB_RD;
          end
        end
`endif
        REQ: begin
          if (bus.mem_req_ready) begin
            cnt   <= 2'd0;
            state <= FILL;
          end
        end
        // The counter wrapping back to 0 after beat 3 is the exit condition.
        FILL: begin
          if (bus.mem_rvalid) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state       <= TAG;
              tag_we_q    <= 1'b1;
              fill_done_q <= 1'b1;
              tag_wdata_q <= {1'b1, tag_q};
            end
          end
        end
        TAG: begin
          state        <= IDLE;
          miss_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Miss context and writeback data hold; plain data, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.miss_valid) begin
      tag_q  <= bus.miss_addr[AW-1 -: TAGW];
      idx_q  <= bus.miss_addr[2 +: IDXW];
      way_q  <= bus.miss_way;
`ifdef REFILL_WRITEBACK_EN
      vtag_q <= bus.victim_tag;
`endif
    end
`ifdef REFILL_WRITEBACK_EN
    if (state == WB_WR && wb_first_q) wb_hold_q <= bus.arr_rdata;
`endif
  end

  // Memory request and array strobes decoded from the current state.
  always_comb begin
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_wdata     = '0;
    bus.arr_we        = 1'b0;
    bus.arr_re        = 1'b0;
    bus.arr_way       = 2'd0;
    bus.arr_index     = '0;
    bus.arr_word      = 2'd0;
    bus.arr_wdata     = '0;
    case (state)
      REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {tag_q, idx_q, 2'b00};
      end
      FILL: begin
        bus.arr_we    = bus.mem_rvalid;
        bus.arr_way   = way_q;
        bus.arr_index = idx_q;
        bus.arr_word  = cnt;
        bus.arr_wdata = bus.mem_rdata;
      end
`ifdef REFILL_WRITEBACK_EN
      WB_RD: begin
        bus.arr_re    = 1'b1;
        bus.arr_way   = way_q;
        bus.arr_index = idx_q;
        bus.arr_word  = cnt;
      end
      // First WB_WR cycle forwards the fresh array read; later cycles use the hold.
      WB_WR: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
        bus.mem_req_addr  = {vtag_q, idx_q, cnt};
        bus.mem_wdata     = wb_first_q ? bus.arr_rdata : wb_hold_q;
      end
`endif
      default: ;
    endcase
  end

  assign bus.miss_ready = miss_ready_q;
  assign bus.tag_we     = tag_we_q;
  assign bus.tag_wdata  = tag_wdata_q;
  assign bus.fill_done  = fill_done_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: stimulus pushes expected memory
// requests, array writes, tag writes and fill latencies; a negedge monitor
// pops and compares whenever the DUT presents them.
module tb_cache_refill_ctrl;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int IDXW = 4;
  localparam int TAGW = AW - IDXW - 2;
`ifdef REFILL_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   t0   = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  cache_refill_ctrl_if #(.AW(AW), .DW(DW), .IDXW(IDXW)) bus ();

  cache_refill_ctrl #(.AW(AW), .DW(DW), .IDXW(IDXW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
  typedef struct { logic [1:0] way; logic [IDXW-1:0] idx; logic [1:0] word; logic [DW-1:0] data; } wr_t;

  req_t          exp_req_q[$];
  wr_t           exp_arr_q[$];
  logic [TAGW:0] exp_tag_q[$];
  int            exp_lat_q[$];

  logic [DW-1:0] ref_arr [4][16][4];
  bit            filled  [4][16];
  logic [DW-1:0] arr_mem [4][16][4];
  logic [DW-1:0] beat_d  [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Data-array model with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.arr_we) arr_mem[bus.arr_way][bus.arr_index][bus.arr_word] <= bus.arr_wdata;
    if (bus.arr_re) bus.arr_rdata <= arr_mem[bus.arr_way][bus.arr_index][bus.arr_word];
  end

  // Monitor: inputs change just after posedge, so negedge sees settled values.
  initial begin
    req_t mr;
    wr_t  mw;
    bit   prev_fd;
    prev_fd = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_fd = 1'b0;
      end else begin
        if (prev_fd) chk("miss_ready_after_done", bus.miss_ready, 1);
        prev_fd = bus.fill_done;
        if (bus.mem_req_valid) begin
          if (exp_req_q.size() == 0) chk("req_unexpected", bus.mem_req_valid, 0);
          else begin
            mr = exp_req_q[0];
            chk("req_we", bus.mem_req_we, mr.we);
            chk("req_addr", bus.mem_req_addr, mr.addr);
            if (mr.we) chk("req_wdata", bus.mem_wdata, mr.data);
            if (bus.mem_req_ready) void'(exp_req_q.pop_front());
          end
        end
        if (bus.arr_we) begin
          if (exp_arr_q.size() == 0) chk("arr_we_unexpected", bus.arr_we, 0);
          else begin
            mw = exp_arr_q.pop_front();
            chk("arr_way", bus.arr_way, mw.way);
            chk("arr_index", bus.arr_index, mw.idx);
            chk("arr_word", bus.arr_word, mw.word);
            chk("arr_wdata", bus.arr_wdata, mw.data);
          end
        end
        if (bus.tag_we) begin
          if (exp_tag_q.size() == 0) chk("tag_we_unexpected", bus.tag_we, 0);
          else chk("tag_wdata", bus.tag_wdata, exp_tag_q.pop_front());
          chk("fill_done_with_tag", bus.fill_done, 1);
        end else if (bus.fill_done) begin
          chk("fill_done_without_tag", bus.tag_we, 1);
        end
        if (bus.fill_done) begin
          if (exp_lat_q.size() == 0) chk("fill_done_unexpected", bus.fill_done, 0);
          else chk("fill_latency", 64'(cyc - t0 + 1), 64'(exp_lat_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (bus.mem_req_valid !== 1'b1 && n < 100) begin tick(); n++; end
    chk("req_valid_wait", bus.mem_req_valid, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.miss_ready !== 1'b1 && n < 100) begin tick(); n++; end
    chk("miss_ready_wait", bus.miss_ready, 1);
  endtask

  task automatic serve_req(input int stall);
    wait_req();
    repeat (stall) tick();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
  endtask

  // One refill: build expectations from address arithmetic, then drive it.
  task automatic do_miss(input logic [AW-1:0] addr, input logic [1:0] way, input logic dirty,
                         input logic [TAGW-1:0] vtag, input int s_rd, input int lat,
                         input int gap_max, input int wstall_max, input bit rst_mid);
    logic [IDXW-1:0] idx;
    logic [TAGW-1:0] tag;
    bit wb;
    int sw[4];
    int gap[4];
    int wbc, g, nb;
    idx = IDXW'((addr / 4) % (1 << IDXW));
    tag = TAGW'(addr / (1 << (IDXW + 2)));
    wb  = WB_EN && dirty;
    wbc = 0;
    for (int w = 0; w < 4; w++) begin
      sw[w] = int'($urandom_range(wstall_max, 0));
      if (wb) begin
        exp_req_q.push_back('{we: 1'b1,
          addr: AW'(vtag) * (1 << (IDXW + 2)) + AW'(idx) * 4 + AW'(w),
          data: ref_arr[way][idx][w]});
        wbc += 2 + sw[w];
      end
    end
    exp_req_q.push_back('{we: 1'b0, addr: (addr / 4) * 4, data: '0});
    g = 0;
    for (int k = 0; k < 4; k++) begin
      gap[k] = (k == 0) ? lat : int'($urandom_range(gap_max, 0));
      if (k > 0) g += gap[k];
    end
    nb = rst_mid ? 2 : 4;
    for (int k = 0; k < nb; k++) exp_arr_q.push_back('{way: way, idx: idx, word: 2'(k), data: beat_d[k]});
    if (!rst_mid) begin
      for (int k = 0; k < 4; k++) ref_arr[way][idx][k] = beat_d[k];
      filled[way][idx] = 1'b1;
      exp_tag_q.push_back({1'b1, tag});
      exp_lat_q.push_back(6 + lat + s_rd + g + wbc);
    end else begin
      filled[way][idx] = 1'b0;
    end

    wait_idle();
    bus.miss_valid   = 1'b1;
    bus.miss_addr    = addr;
    bus.miss_way     = way;
    bus.victim_dirty = dirty;
    bus.victim_tag   = vtag;
    tick();
    t0 = cyc;
    bus.miss_valid   = 1'b0;
    bus.miss_addr    = $urandom;
    bus.miss_way     = 2'($urandom);
    bus.victim_dirty = 1'($urandom);
    bus.victim_tag   = TAGW'($urandom);
    if (wb) for (int w = 0; w < 4; w++) serve_req(sw[w]);
    serve_req(s_rd);
    for (int k = 0; k < nb; k++) begin
      repeat (gap[k]) tick();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = beat_d[k];
      tick();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
    end
    if (rst_mid) begin
      rstn = 1'b0;
      #1;
      chk("rst_mid_miss_ready", bus.miss_ready, 1);
      chk("rst_mid_tag_we", bus.tag_we, 0);
      chk("rst_mid_fill_done", bus.fill_done, 0);
      chk("rst_mid_req_valid", bus.mem_req_valid, 0);
      tick();
      rstn = 1'b1;
      for (int k = 2; k < 4; k++) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = $urandom;
        tick();
        bus.mem_rvalid = 1'b0;
      end
    end
  endtask

  task automatic rand_beats();
    for (int k = 0; k < 4; k++) beat_d[k] = $urandom;
  endtask

  initial begin
    logic [1:0] way;
    bus.miss_valid    = 1'b0;
    bus.miss_addr     = '0;
    bus.miss_way      = 2'd0;
    bus.victim_dirty  = 1'b0;
    bus.victim_tag    = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
    repeat (3) tick();
    chk("rst_miss_ready", bus.miss_ready, 1);
    chk("rst_req_valid", bus.mem_req_valid, 0);
    chk("rst_req_we", bus.mem_req_we, 0);
    chk("rst_arr_we", bus.arr_we, 0);
    chk("rst_tag_we", bus.tag_we, 0);
    chk("rst_fill_done", bus.fill_done, 0);
    rstn = 1'b1;
    tick();
    chk("post_rst_miss_ready", bus.miss_ready, 1);
    chk("post_rst_arr_re", bus.arr_re, 0);

    // Clean miss with the reference line.
    beat_d[0] = 32'hFF0000FF; beat_d[1] = 32'hF0F0F0F0;
    beat_d[2] = 32'h00FFFF00; beat_d[3] = 32'h00FF00FF;
    do_miss(32'h0FF001F2, 2'd1, 1'b0, '0, 0, 0, 0, 0, 1'b0);

    // Request backpressure of 5 cycles.
    rand_beats();
    do_miss(32'h12345678, 2'd3, 1'b0, '0, 5, 1, 0, 0, 1'b0);

    // Gapped beats, then a stray beat while idle.
    rand_beats();
    do_miss(32'hCAFE0024, 2'd0, 1'b0, '0, 0, 2, 3, 0, 1'b0);
    wait_idle();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = $urandom;
    tick();
    bus.mem_rvalid = 1'b0;

    // Reset after beat 1, then a normal miss.
    rand_beats();
    do_miss(32'h00ABC0E8, 2'd2, 1'b0, '0, 0, 1, 1, 0, 1'b1);
    rand_beats();
    do_miss(32'h00ABC0E8, 2'd2, 1'b0, '0, 1, 0, 1, 0, 1'b0);

    // Dirty-victim line: install it, then evict it with a miss to 0x1F0.
    beat_d[0] = 32'h11111111; beat_d[1] = 32'hAAAAAAAA;
    beat_d[2] = 32'h00000000; beat_d[3] = 32'hEEFFEEFF;
    do_miss(32'h0AA001F0, 2'd2, 1'b0, '0, 0, 0, 0, 0, 1'b0);
    rand_beats();
    do_miss(32'h000001F0, 2'd2, 1'b1, 26'h02A8007, 0, 0, 0, 0, 1'b0);

    // Randomized traffic; dirty victims only on lines the bench has filled.
    for (int i = 0; i < 30; i++) begin
      logic [AW-1:0] a;
      logic [IDXW-1:0] ix;
      logic d;
      a   = $urandom;
      way = 2'($urandom);
      ix  = IDXW'((a / 4) % (1 << IDXW));
      d   = filled[way][ix] ? 1'($urandom) : 1'b0;
      rand_beats();
      do_miss(a, way, d, TAGW'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
              2, 2, 1'b0);
    end

    wait_idle();
    repeat (3) tick();
    chk("req_queue_empty", 64'(exp_req_q.size()), 0);
    chk("arr_queue_empty", 64'(exp_arr_q.size()), 0);
    chk("tag_queue_empty", 64'(exp_tag_q.size()), 0);
    chk("lat_queue_empty", 64'(exp_lat_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d required finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
